// File: rtl/nios_dbgmem_pkg.sv
// Shared types for the debug-memory arbiter: FSM states, grant owner, word width.
// No logic; no latency; no backpressure.
package nios_dbgmem_pkg;
  localparam int WORD_W     = 32;
  localparam int RAM_RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, CPU_RD, JTAG_RD} state_t;
  typedef enum logic       {GNT_CPU, GNT_JTAG}     grant_t;
endpackage

// File: rtl/dbgmem_rr_arbiter.sv
// Two-requester round-robin (CPU vs JTAG) with a JTAG priority override.
// Latency: combinational grant. Backpressure: the loser simply holds its request.
module dbgmem_rr_arbiter
  import nios_dbgmem_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic req_cpu,
  input  logic req_jtag,
  input  logic prio_jtag,
  output logic gnt_cpu,
  output logic gnt_jtag
);
  grant_t last_grant;

  always_comb begin
    gnt_cpu  = 1'b0;
    gnt_jtag = 1'b0;
    if (en) begin
      if (req_jtag && (!req_cpu || prio_jtag || last_grant == GNT_CPU))
        gnt_jtag = 1'b1;
      else if (req_cpu)
        gnt_cpu = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      last_grant <= GNT_CPU;
    else if (gnt_jtag)
      last_grant <= GNT_JTAG;
    else if (gnt_cpu)
      last_grant <= GNT_CPU;
  end
endmodule

// File: rtl/soc_system_nios2_gen2_cpu_debug_mem_arbiter.sv
// Shares the debug RAM between the JTAG command path and the CPU slave; DBG_RAM_PROTECT_EN adds CPU write protection.
// Latency: writes complete in the grant cycle, reads one cycle later (JTAG data/done one cycle after that).
// Backpressure: CPU stalled by avs_waitrequest; JTAG requests while jtag_busy are ignored.
module soc_system_nios2_gen2_cpu_debug_mem_arbiter
  import nios_dbgmem_pkg::*;
#(
  parameter int                ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] PROTECT_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              debugack,
  input  logic              jtag_addr_load,
  input  logic [ADDR_W-1:0] jtag_addr_in,
  input  logic              jtag_rd_req,
  input  logic              jtag_wr_req,
  input  logic [WORD_W-1:0] jtag_wdata,
  output logic [WORD_W-1:0] jtag_rdata,
  output logic              jtag_busy,
  output logic              jtag_done,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [WORD_W-1:0] avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [WORD_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [3:0]        ram_be,
  output logic [WORD_W-1:0] ram_wdata,
  input  logic [WORD_W-1:0] ram_rdata,
  output logic              prot_violation
);
  state_t              state;
  logic                pending;
  logic                pend_wr;
  logic [WORD_W-1:0]   pend_wdata;
  logic [ADDR_W-1:0]   ctr;
  logic                gnt_cpu;
  logic                gnt_jtag;
  logic                cpu_wr_blocked;

  // A fresh request is offered to the arbiter in the cycle it arrives, so an idle
  // JTAG path competes immediately instead of losing a cycle to the pending flag.
  logic jtag_in_flight;
  logic jtag_accept;
  logic jtag_req;
  logic jtag_op_wr;
  logic [ADDR_W-1:0] jtag_op_addr;
  logic [WORD_W-1:0] jtag_op_wdata;

  assign jtag_in_flight = pending || (state == JTAG_RD);
  assign jtag_accept    = (jtag_rd_req || jtag_wr_req) && !jtag_in_flight && !reset;
  assign jtag_req       = pending || jtag_accept;
  assign jtag_op_wr     = pending ? pend_wr : jtag_wr_req;
  assign jtag_op_addr   = (!pending && jtag_addr_load) ? jtag_addr_in : ctr;
  assign jtag_op_wdata  = pending ? pend_wdata : jtag_wdata;

  dbgmem_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .en        (state == IDLE && !reset),
    .req_cpu   (avs_read || avs_write),
    .req_jtag  (jtag_req),
    .prio_jtag (debugack),
    .gnt_cpu   (gnt_cpu),
    .gnt_jtag  (gnt_jtag)
  );

`ifdef DBG_RAM_PROTECT_EN
  assign cpu_wr_blocked = avs_write && (avs_address >= PROTECT_BASE) && !debugack;

  always_ff @(posedge clk) begin
    if (reset)
      prot_violation <= 1'b0;
    else if (gnt_cpu && cpu_wr_blocked)
      prot_violation <= 1'b1;
  end
`else
  logic unused_protect_base;
  assign unused_protect_base = ^PROTECT_BASE;
  assign cpu_wr_blocked      = 1'b0;
  assign prot_violation      = 1'b0;
`endif

  always_comb begin
    ram_addr  = avs_address;
    ram_we    = 1'b0;
    ram_be    = avs_byteenable;
    ram_wdata = avs_writedata;
    if (gnt_jtag) begin
      ram_addr  = jtag_op_addr;
      ram_we    = jtag_op_wr;
      ram_be    = 4'hF;
      ram_wdata = jtag_op_wdata;
    end else if (gnt_cpu) begin
      ram_we = avs_write && !cpu_wr_blocked;
    end
  end

  assign avs_readdata    = ram_rdata;
  assign avs_waitrequest = reset || !((gnt_cpu && avs_write) || state == CPU_RD);
  assign jtag_busy       = !reset && jtag_in_flight;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pending    <= 1'b0;
      pend_wr    <= 1'b0;
      pend_wdata <= '0;
      ctr        <= '0;
      jtag_rdata <= '0;
      jtag_done  <= 1'b0;
    end else begin
      jtag_done <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_jtag) begin
            state     <= jtag_op_wr ? IDLE : JTAG_RD;
            jtag_done <= jtag_op_wr;
          end else if (gnt_cpu && !avs_write) begin
            state <= CPU_RD;
          end
        end
        CPU_RD:  state <= IDLE;
        JTAG_RD: begin
          jtag_rdata <= ram_rdata;
          jtag_done  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (gnt_jtag) begin
        pending <= 1'b0;
      end else if (jtag_accept) begin
        pending    <= 1'b1;
        pend_wr    <= jtag_wr_req;
        pend_wdata <= jtag_wdata;
      end

      if (gnt_jtag)
        ctr <= jtag_op_addr + 1'b1;
      else if (jtag_addr_load && !jtag_in_flight)
        ctr <= jtag_addr_in;
    end
  end
endmodule

// File: tb/tb_soc_system_nios2_gen2_cpu_debug_mem_arbiter.sv
// Randomized + directed bench for the debug-memory arbiter with a RAM model,
// a word-level reference memory and expectation queues drained by a monitor.
module tb_soc_system_nios2_gen2_cpu_debug_mem_arbiter;
`ifdef DBG_RAM_PROTECT_EN
  localparam bit PROT = 1'b1;
`else
  localparam bit PROT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        debugack = 1'b0;
  logic        jtag_addr_load = 1'b0;
  logic [7:0]  jtag_addr_in = '0;
  logic        jtag_rd_req = 1'b0;
  logic        jtag_wr_req = 1'b0;
  logic [31:0] jtag_wdata = '0;
  logic [31:0] jtag_rdata;
  logic        jtag_busy;
  logic        jtag_done;
  logic [7:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic [3:0]  avs_byteenable = 4'hF;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        prot_violation;

  soc_system_nios2_gen2_cpu_debug_mem_arbiter dut (
    .clk(clk), .reset(reset), .debugack(debugack),
    .jtag_addr_load(jtag_addr_load), .jtag_addr_in(jtag_addr_in),
    .jtag_rd_req(jtag_rd_req), .jtag_wr_req(jtag_wr_req), .jtag_wdata(jtag_wdata),
    .jtag_rdata(jtag_rdata), .jtag_busy(jtag_busy), .jtag_done(jtag_done),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_be(ram_be), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .prot_violation(prot_violation)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [256] = '{default: 32'h0};
  logic [31:0] ref_mem [256] = '{default: 32'h0};
  logic [7:0]  ref_ctr = '0;

  always @(posedge clk) begin
    if (ram_we)
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    ram_rdata <= mem[ram_addr];
  end

  typedef struct { bit rd; logic [31:0] d; } jexp_t;
  jexp_t       jq[$];
  logic [31:0] cq[$];
  jexp_t       jr;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: every completed CPU read and every JTAG done pops one expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (avs_read && !avs_write && !avs_waitrequest) begin
        if (cq.size() == 0) flag("cpu_read_unexpected");
        else chk("cpu_rdata", avs_readdata, cq.pop_front());
      end
      if (jtag_done) begin
        if (jq.size() == 0) flag("jtag_done_unexpected");
        else begin
          jr = jq.pop_front();
          if (jr.rd) chk("jtag_rdata", jtag_rdata, jr.d);
        end
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    ref_ctr = '0;
  endtask

  task automatic jtag_op(input bit wr, input bit load, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    @(posedge clk); #1;
    while (jtag_busy && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) flag("jtag_busy_timeout");
    if (load) ref_ctr = a;
    jtag_addr_load = load;
    jtag_addr_in   = a;
    jtag_wr_req    = wr;
    jtag_rd_req    = !wr;
    jtag_wdata     = d;
    if (wr) begin
      ref_mem[ref_ctr] = d;
      jq.push_back('{rd: 1'b0, d: 32'h0});
    end else begin
      jq.push_back('{rd: 1'b1, d: ref_mem[ref_ctr]});
    end
    ref_ctr++;
    @(posedge clk); #1;
    jtag_addr_load = 1'b0;
    jtag_wr_req    = 1'b0;
    jtag_rd_req    = 1'b0;
  endtask

  task automatic cpu_op(input bit wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, input bit lands);
    int n = 0;
    bit done = 1'b0;
    @(posedge clk); #1;
    avs_address = a; avs_writedata = d; avs_byteenable = be;
    avs_write = wr; avs_read = !wr;
    if (wr && lands) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    end else if (!wr) begin
      cq.push_back(ref_mem[a]);
    end
    while (!done && n < 50) begin
      @(negedge clk);
      if (!avs_waitrequest) done = 1'b1;
      else begin
        n++;
        @(posedge clk); #1;
      end
    end
    if (!done) flag("cpu_wait_timeout");
    @(posedge clk); #1;
    avs_read = 1'b0; avs_write = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_waitrequest", avs_waitrequest, 1);
    chk("rst_busy", jtag_busy, 0);
    chk("rst_done", jtag_done, 0);
    chk("rst_rdata", jtag_rdata, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_prot", prot_violation, 0);

    // Basic JTAG write / read-back, then auto-increment
    jtag_op(1, 1, 8'h10, 32'hDEADBEEF);
    jtag_op(0, 1, 8'h10, 32'h0);
    jtag_op(1, 0, 8'h00, 32'h12345678);
    @(negedge clk);
    chk("t1_mem10", mem[8'h10], 32'hDEADBEEF);
    chk("t1_mem11_autoinc", mem[8'h11], 32'h12345678);

    // Simultaneous CPU and JTAG read right after reset: JTAG wins
    do_reset();
    @(posedge clk); #1;
    jtag_addr_load = 1; jtag_addr_in = 8'h10; jtag_rd_req = 1;
    avs_read = 1; avs_address = 8'h11;
    jq.push_back('{rd: 1'b1, d: ref_mem[8'h10]});
    cq.push_back(ref_mem[8'h11]);
    ref_ctr = 8'h11;
    @(negedge clk);
    chk("t2_jtag_first_addr", ram_addr, 8'h10);
    chk("t2_cpu_stall_t0", avs_waitrequest, 1);
    @(posedge clk); #1;
    jtag_addr_load = 0; jtag_rd_req = 0;
    @(negedge clk);
    chk("t2_cpu_stall_t1", avs_waitrequest, 1);
    @(negedge clk);
    chk("t2_jtag_done_t2", jtag_done, 1);
    chk("t2_cpu_stall_t2", avs_waitrequest, 1);
    @(negedge clk);
    chk("t2_cpu_ack_t3", avs_waitrequest, 0);
    @(posedge clk); #1;
    avs_read = 0;

    // debugack: held CPU write waits behind three back-to-back JTAG writes
    debugack = 1;
    @(posedge clk); #1;
    avs_write = 1; avs_address = 8'h40; avs_writedata = 32'hC0FFEE00; avs_byteenable = 4'hF;
    for (int i = 0; i < 3; i++) begin
      jtag_wr_req = 1; jtag_addr_load = (i == 0); jtag_addr_in = 8'h50;
      jtag_wdata = 32'hA5A50000 + i;
      if (i == 0) ref_ctr = 8'h50;
      ref_mem[ref_ctr] = jtag_wdata;
      ref_ctr++;
      jq.push_back('{rd: 1'b0, d: 32'h0});
      @(negedge clk);
      chk("t3_cpu_stalled", avs_waitrequest, 1);
      chk("t3_jtag_addr", ram_addr, 8'h50 + i);
      @(posedge clk); #1;
    end
    jtag_wr_req = 0; jtag_addr_load = 0;
    ref_mem[8'h40] = 32'hC0FFEE00;
    @(negedge clk);
    chk("t3_cpu_after", avs_waitrequest, 0);
    chk("t3_cpu_addr", ram_addr, 8'h40);
    @(posedge clk); #1;
    avs_write = 0; debugack = 0;

    // Counter wrap
    jtag_op(1, 1, 8'hFF, 32'h0F0F0F0F);
    jtag_op(1, 0, 8'h00, 32'hF0F0F0F0);
    @(negedge clk);
    chk("t4_memFF", mem[8'hFF], 32'h0F0F0F0F);
    chk("t4_mem00_wrap", mem[8'h00], 32'hF0F0F0F0);

    // Protected region
    cpu_op(1, 8'hC4, 32'h11112222, 4'hF, !PROT);
    @(negedge clk);
    chk("t5_prot_flag", prot_violation, PROT);
    chk("t5_memC4_a", mem[8'hC4], PROT ? 32'h0 : 32'h11112222);
    debugack = 1;
    cpu_op(1, 8'hC4, 32'h33334444, 4'hF, 1);
    debugack = 0;
    @(negedge clk);
    chk("t5_memC4_b", mem[8'hC4], 32'h33334444);

    // Reset while a JTAG read is in flight
    @(posedge clk); #1;
    jtag_rd_req = 1;
    @(posedge clk); #1;
    jtag_rd_req = 0; reset = 1;
    @(negedge clk);
    chk("t6_wait_in_reset", avs_waitrequest, 1);
    chk("t6_we_in_reset", ram_we, 0);
    @(posedge clk); #1;
    reset = 0; ref_ctr = '0;
    @(negedge clk);
    chk("t6_no_done", jtag_done, 0);
    chk("t6_busy", jtag_busy, 0);
    chk("t6_wait", avs_waitrequest, 1);
    @(negedge clk);
    chk("t6_no_done_late", jtag_done, 0);

    // Random concurrent traffic on disjoint address windows
    for (int round = 0; round < 2; round++) begin
      debugack = round[0];
      fork
        begin
          for (int k = 0; k < 25; k++) begin
            logic [7:0] a;
            bit ld;
            a  = 8'($urandom_range(8'h20, 8'h5F));
            ld = (ref_ctr < 8'h20) || (ref_ctr > 8'h5F) || ($urandom_range(0, 3) == 0);
            jtag_op($urandom_range(0, 1) == 1, ld, a, $urandom);
          end
        end
        begin
          for (int k = 0; k < 25; k++) begin
            logic [3:0] be;
            be = 4'($urandom_range(1, 15));
            cpu_op($urandom_range(0, 1) == 1, 8'($urandom_range(8'h80, 8'hBF)), $urandom, be, 1);
          end
        end
      join
    end

    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("jq_drained", jq.size(), 0);
    chk("cq_drained", cq.size(), 0);
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) chk($sformatf("mem[%0h]", i), mem[i], ref_mem[i]);
      else n_cmp++;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
